bht_update_ctrl: RTL
====================

# bht_update_ctrl

Controller for the 256-entry branch history table of 2-bit saturating counters. Shares the table's single combinational read port between the fetch-stage predict lookup and the commit-stage update path. Updates are buffered and applied as a read-modify-write sequence. Owns the power-up and flush initialisation sweep of the table.

## Interface
- IDX_W, 8: table index width; table depth is 2**IDX_W.
- FIFO_DEPTH, 2: update buffer entries.
- STARVE_LIMIT, 4: consecutive denied RD cycles before an update preempts predict.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  one-cycle pulse; restarts the init sweep.
- pred_valid  in  1  fetch requests a lookup this cycle.
- pred_idx  in  IDX_W  lookup index.
- pred_ready  out  1  lookup granted this cycle.
- pred_taken  out  1  counter[1] of pred_idx; meaningful only when pred_valid && pred_ready.
- upd_valid  in  1  commit offers an update.
- upd_idx  in  IDX_W  index to update.
- upd_taken  in  1  resolved branch direction.
- upd_ready  out  1  update accepted when upd_valid && upd_ready at the edge.
- init_done  out  1  high once the sweep completes, until the next flush or reset.

## Operation
- States: INIT, IDLE, RD, WR.
- Reset value of every output is 0: pred_ready, pred_taken, upd_ready and init_done. Internally, state=INIT, sweep index=0, FIFO empty, starve_cnt=0.
- INIT: writes WNT (2'b01) to entry sweep_idx each cycle, then increments sweep_idx. After writing entry 255, goes to IDLE and sets init_done. pred_ready, pred_taken and upd_ready are 0 throughout.
- flush in any state: FIFO cleared, any RD/WR in flight aborted with no table write, sweep_idx=0, init_done=0, next state INIT. A flush during INIT restarts the sweep at 0.
- IDLE: if the FIFO is non-empty, go to RD.
- RD: the update owns the read port when !pred_valid || starve_cnt==STARVE_LIMIT-1. When granted, capture table[head.idx] and go to WR. Otherwise starve_cnt++ and stay in RD. starve_cnt clears on leaving RD.
- WR: write sat(captured, head.taken) to table[head.idx] and pop the FIFO. Go to RD if the FIFO is still non-empty after the pop, else IDLE.
- sat(): taken increments and saturates at 2'b11; not-taken decrements and saturates at 2'b00.
- pred_ready = (state!=INIT) && !(state==RD && update granted while pred_valid).
- upd_ready = (state!=INIT) && (FIFO not full || popping this cycle). A simultaneous push and pop on a full FIFO is legal.
- Updates are applied strictly in acceptance order. Back-to-back updates to the same index are applied cumulatively, because each WR completes before the next RD.
- No bypass: a predict of an index with an update pending or in WR returns the old table value.

## Timing
- Predict: combinational; pred_taken is valid in the same cycle as pred_valid.
- Update with no contention, accepted at edge t: RD during cycle t+1→t+2, WR during t+2→t+3. Table updated at edge t+3; predicts in cycle t+3 see the new value.
- Each update costs 2 cycles (RD+WR) plus contention stalls. Sustained throughput is 1 update per 2 cycles.
- Worst-case predict denial is 1 cycle in every STARVE_LIMIT RD cycles.
- Init sweep: 256 cycles after reset release or after a flush edge; init_done rises on the edge after entry 255 is written.

## Structure
- bht_pkg holds:
  - the state enum;
  - the counter_t 2-bit typedef;
  - constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11, and INIT_VAL=WNT;
  - the update entry struct {idx, taken};
  - a sat() function.
- Sub-module counter_table: a 2**IDX_W x 2 array with one combinational read port (index, dataout) and one synchronous write port (write, write_idx, datain). It has no reset; its contents are defined only by the sweep.
- Controller top: FSM, FIFO, starve counter, and read-index mux (sweep / update head / pred_idx).

## Test plan
- Reset release, then idle: init_done rises 256 cycles later. A predict of indices 0, 128 and 255 then returns pred_taken=0 (WNT) with pred_ready=1.
- Three taken updates to idx 5, no predict traffic: table[5] goes 01→10→11→11. pred_taken=1 after the first update lands at t+3. A fourth not-taken update gives 10.
- pred_valid held high while an update is pending: pred_ready drops for exactly 1 cycle after 3 denied RD cycles, and the update completes.
- FIFO full (2 entries) with upd_valid held: upd_ready=0 until the WR pop cycle, when a simultaneous push/pop is accepted. All 3 updates are applied in order.
- flush asserted during WR of idx 9 (01→10 pending): no write lands. After 256 cycles table[9]=01, the FIFO is empty and init_done=1.
- rst_n asserted mid-sweep at sweep_idx=100: all outputs are 0 immediately. After release the sweep restarts at 0 and takes the full 256 cycles.

Source files
------------

// File: rtl/bht_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bht_pkg : shared state, counter and update-entry types for the BHT controller
// rev 1.0
// ----------------------------------------------------------------------------
package bht_pkg;

  localparam int BHT_IDX_W = 8;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  typedef logic [1:0] counter_t;

  localparam counter_t SNT      = 2'b00;
  localparam counter_t WNT      = 2'b01;
  localparam counter_t WT       = 2'b10;
  localparam counter_t ST       = 2'b11;
  localparam counter_t INIT_VAL = WNT;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] idx;
    logic                 taken;
  } upd_entry_t;

  function automatic counter_t sat(input counter_t cur, input logic taken);
    counter_t res;
    case (cur)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      default: res = taken ? ST  : WT;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_update_ctrl_counter_table.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_table : 2-bit counter array, one combinational read, one sync write
// rev 1.0
// ----------------------------------------------------------------------------
module counter_table
  import bht_pkg::*;
#(
  parameter int IDX_W = BHT_IDX_W
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] index,
  output logic [1:0]       dataout,
  input  logic             write,
  input  logic [IDX_W-1:0] write_idx,
  input  logic [1:0]       datain
);

  // No reset: contents are established by the controller's init sweep.
  counter_t mem [0:(2**IDX_W)-1];

  always_ff @(posedge clk) begin
    if (write) begin
      mem[write_idx] <= datain;
    end
  end

  assign dataout = mem[index];

endmodule
`default_nettype wire

// File: rtl/bht_update_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bht_update_ctrl : arbitrates the BHT read port between predict and buffered
//                   read-modify-write updates; owns the init/flush sweep
// rev 1.0
// ----------------------------------------------------------------------------
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W        = BHT_IDX_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_ready,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             init_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_last;

  upd_entry_t       fifo_mem [0:FIFO_DEPTH-1];
  upd_entry_t       head, new_entry;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  logic             fifo_full, push, pop;

  logic [STV_W-1:0] starve_cnt;
  logic             rd_grant;
  counter_t         captured;

  logic [IDX_W-1:0] read_idx, write_idx;
  logic [1:0]       read_data, write_data;
  logic             table_we;

  counter_table #(
    .IDX_W (IDX_W)
  ) u_table (
    .clk       (clk),
    .index     (read_idx),
    .dataout   (read_data),
    .write     (table_we),
    .write_idx (write_idx),
    .datain    (write_data)
  );

  assign head       = fifo_mem[rd_ptr];
  assign new_entry  = '{idx: upd_idx, taken: upd_taken};
  assign sweep_last = &sweep_idx;
  assign fifo_full  = (count == FULL_CNT);

  // The update takes the port when fetch is quiet or has starved it long enough.
  assign rd_grant   = (state == RD) && (!pred_valid || (starve_cnt == STARVE_MAX));
  assign pop        = (state == WR);
  assign upd_ready  = (state != INIT) && (!fifo_full || pop);
  assign push       = upd_valid && upd_ready && !flush;
  assign pred_ready = (state != INIT) && !(rd_grant && pred_valid);
  assign pred_taken = pred_ready && read_data[1];

  always_comb begin
    count_nxt = count;
    if (push) count_nxt = count_nxt + ONE_CNT;
    if (pop)  count_nxt = count_nxt - ONE_CNT;
  end

  always_comb begin
    read_idx = pred_idx;
    if (state == INIT) begin
      read_idx = sweep_idx;
    end else if (rd_grant) begin
      read_idx = head.idx;
    end
  end

  // A flush cycle suppresses every table write, including an in-flight WR.
  always_comb begin
    table_we   = 1'b0;
    write_idx  = sweep_idx;
    write_data = INIT_VAL;
    if (!flush) begin
      if (state == INIT) begin
        table_we = 1'b1;
      end else if (state == WR) begin
        table_we   = 1'b1;
        write_idx  = head.idx;
        write_data = sat(captured, head.taken);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep_last) state_nxt = IDLE;
      IDLE:    if (count != '0) state_nxt = RD;
      RD:      if (rd_grant) state_nxt = WR;
      WR:      state_nxt = (count_nxt != '0) ? RD : IDLE;
      default: state_nxt = INIT;
    endcase
    if (flush) state_nxt = INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx <= '0;
      init_done <= 1'b0;
    end else if (flush) begin
      sweep_idx <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      sweep_idx <= sweep_idx + IDX_W'(1);
      if (sweep_last) init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ONE_PTR;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      captured   <= SNT;
    end else if (flush) begin
      starve_cnt <= '0;
    end else if (state == RD) begin
      if (rd_grant) begin
        starve_cnt <= '0;
        captured   <= read_data;
      end else begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
